// File: rtl/bus_arbiter.sv
// Two-master, one-slave round-robin bus arbiter with a per-transfer wait limit.
// A transfer that runs past TIMEOUT slave cycles is completed towards the master with zero data.
module bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic        timeout_o,
  output logic [31:0] to_adr_o
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, RELEASE} state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT);

  state_t      state;
  logic        last_gnt;
  logic [7:0]  wait_cnt;
  logic [31:0] to_adr;

  logic busy;
  logic owner1;
  logic cur_stb;
  logic timeout_hit;

  assign busy    = (state == BUSY0) || (state == BUSY1);
  assign owner1  = (state == BUSY1);
  assign cur_stb = owner1 ? m1_stb_i : m0_stb_i;

  // A slave ack in the limit cycle wins; a withdrawn strobe never times out.
  assign timeout_hit = busy && cur_stb && !s_ack_i && (wait_cnt == WAIT_LIMIT);

  assign timeout_o = timeout_hit;
  assign to_adr_o  = to_adr;

  always_comb begin
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = 32'd0;
    s_dat_o  = 32'd0;
    s_sel_o  = 4'd0;
    m0_ack_o = 1'b0;
    m0_dat_o = 32'd0;
    m1_ack_o = 1'b0;
    m1_dat_o = 32'd0;
    if (busy) begin
      s_stb_o = cur_stb;
      s_we_o  = owner1 ? m1_we_i  : m0_we_i;
      s_adr_o = owner1 ? m1_adr_i : m0_adr_i;
      s_dat_o = owner1 ? m1_dat_i : m0_dat_i;
      s_sel_o = owner1 ? m1_sel_i : m0_sel_i;
      if (owner1) begin
        m1_ack_o = s_ack_i || timeout_hit;
        m1_dat_o = timeout_hit ? 32'd0 : s_dat_i;
      end else begin
        m0_ack_o = s_ack_i || timeout_hit;
        m0_dat_o = timeout_hit ? 32'd0 : s_dat_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      wait_cnt <= 8'd0;
      to_adr   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= 8'd0;
          // On a tie the master that did not win last time gets the bus.
          if (m0_stb_i && m1_stb_i)
            state <= last_gnt ? BUSY0 : BUSY1;
          else if (m0_stb_i)
            state <= BUSY0;
          else if (m1_stb_i)
            state <= BUSY1;
        end
        BUSY0, BUSY1: begin
          if (s_ack_i || timeout_hit) begin
            last_gnt <= owner1;
            state    <= RELEASE;
            if (timeout_hit)
              to_adr <= s_adr_o;
          end else if (!cur_stb) begin
            state <= IDLE;
          end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RELEASE: begin
          wait_cnt <= 8'd0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios followed by randomized
// masters and slave, all compared against a transaction-level reference model.
module tb_bus_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        mstb [2];
  logic        mwe  [2];
  logic [31:0] madr [2];
  logic [31:0] mdat [2];
  logic [3:0]  msel [2];
  logic        m0_ack_o, m1_ack_o;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_ack_i;
  logic [31:0] s_dat_i;
  logic        timeout_o;
  logic [31:0] to_adr_o;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_i(rst_i),
    .m0_stb_i(mstb[0]), .m0_we_i(mwe[0]), .m0_adr_i(madr[0]), .m0_dat_i(mdat[0]), .m0_sel_i(msel[0]),
    .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
    .m1_stb_i(mstb[1]), .m1_we_i(mwe[1]), .m1_adr_i(madr[1]), .m1_dat_i(mdat[1]), .m1_sel_i(msel[1]),
    .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
    .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .timeout_o(timeout_o), .to_adr_o(to_adr_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the bus, whether a cool-down cycle is pending,
  // how long the owner has waited, and who was served last.
  int          owner;
  bit          cooling;
  int          waited;
  int          prev;
  logic [31:0] aborted;

  logic        exp_stb, exp_we, exp_to;
  logic [31:0] exp_adr, exp_dat;
  logic [3:0]  exp_sel;
  logic        exp_ack  [2];
  logic [31:0] exp_rdat [2];

  task automatic model_reset();
    owner = -1; cooling = 0; waited = 0; prev = 1; aborted = 32'd0;
  endtask

  task automatic model_eval();
    exp_stb = 0; exp_we = 0; exp_adr = 0; exp_dat = 0; exp_sel = 0; exp_to = 0;
    for (int m = 0; m < 2; m++) begin
      exp_ack[m]  = 0;
      exp_rdat[m] = 0;
    end
    if (owner >= 0) begin
      exp_stb = mstb[owner];
      exp_we  = mwe[owner];
      exp_adr = madr[owner];
      exp_dat = mdat[owner];
      exp_sel = msel[owner];
      exp_to  = mstb[owner] && !s_ack_i && (waited == TO);
      exp_ack[owner]  = s_ack_i || exp_to;
      exp_rdat[owner] = exp_to ? 32'd0 : s_dat_i;
    end
  endtask

  task automatic model_advance();
    if (!rst_i) model_reset();
    else if (cooling) cooling = 0;
    else if (owner < 0) begin
      if (mstb[0] && mstb[1]) owner = 1 - prev;
      else if (mstb[0]) owner = 0;
      else if (mstb[1]) owner = 1;
      waited = 0;
    end else if (s_ack_i || exp_to) begin
      prev = owner;
      if (exp_to) aborted = madr[owner];
      owner = -1;
      cooling = 1;
    end else if (!mstb[owner]) owner = -1;
    else if (waited < TO) waited++;
  endtask

  // One clock: inputs already driven at posedge+1; compare at posedge+5, then advance.
  task automatic tick();
    model_eval();
    #4;
    check("s_stb", s_stb_o, exp_stb);
    check("s_we", s_we_o, exp_we);
    check("s_adr", s_adr_o, exp_adr);
    check("s_dat", s_dat_o, exp_dat);
    check("s_sel", s_sel_o, exp_sel);
    check("m0_ack", m0_ack_o, exp_ack[0]);
    check("m0_dat", m0_dat_o, exp_rdat[0]);
    check("m1_ack", m1_ack_o, exp_ack[1]);
    check("m1_dat", m1_dat_o, exp_rdat[1]);
    check("timeout", timeout_o, exp_to);
    check("to_adr", to_adr_o, aborted);
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int m);
    mstb[m] = 1'b1;
    mwe[m]  = 1'($urandom);
    madr[m] = $urandom;
    mdat[m] = $urandom;
    msel[m] = 4'($urandom);
  endtask

  initial begin
    int sl_wait;
    int sl_target;
    bit bus_on;

    rst_i = 1'b0; s_ack_i = 1'b0; s_dat_i = 32'd0;
    for (int m = 0; m < 2; m++) begin
      mstb[m] = 0; mwe[m] = 0; madr[m] = 0; mdat[m] = 0; msel[m] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_i = 1'b1;
    #1;
    check("rst_stb", s_stb_o, 0);
    check("rst_ack0", m0_ack_o, 0);
    check("rst_ack1", m1_ack_o, 0);
    check("rst_to", timeout_o, 0);
    check("rst_toadr", to_adr_o, 0);

    // Round-robin with both masters holding and a zero-wait slave.
    mstb[0] = 1; madr[0] = 32'hA0; mstb[1] = 1; madr[1] = 32'hB0;
    tick();
    for (int g = 0; g < 4; g++) begin
      s_ack_i = 1; s_dat_i = 32'h100 + 32'(g);
      #1;
      check("rr_adr", s_adr_o, (g % 2) ? 32'hB0 : 32'hA0);
      check("rr_m1ack", m1_ack_o, 32'(g % 2));
      tick();
      s_ack_i = 0;
      tick();
      if (g == 3) begin mstb[0] = 0; mstb[1] = 0; end
      tick();
    end

    // Single read from m0 with two slave wait cycles.
    mstb[0] = 1; madr[0] = 32'h100; mwe[0] = 0;
    tick();
    #1; check("rd_stb_c1", s_stb_o, 1);
    tick();
    tick();
    s_ack_i = 1; s_dat_i = 32'hCAFEF00D;
    #1; check("rd_ack_c3", m0_ack_o, 1); check("rd_dat_c3", m0_dat_o, 32'hCAFEF00D);
    tick();
    s_ack_i = 0;
    #1; check("rd_release_mask", s_stb_o, 0);
    tick();
    mstb[0] = 0;
    tick();

    // Timeout on m1 with a silent slave.
    mstb[1] = 1; madr[1] = 32'h2000; mwe[1] = 0; s_dat_i = 32'h12345678;
    tick();
    for (int c = 1; c <= 5; c++) begin
      #1;
      check("to_pulse", timeout_o, 32'(c == 5));
      if (c == 5) begin
        check("to_ack", m1_ack_o, 1);
        check("to_dat", m1_dat_o, 0);
      end
      tick();
    end
    mstb[1] = 0;
    #1; check("to_pulse_end", timeout_o, 0); check("to_adr", to_adr_o, 32'h2000);
    tick();
    tick();

    // Slave ack lands exactly in the limit cycle: normal completion.
    mstb[0] = 1; madr[0] = 32'h3000;
    tick();
    for (int c = 1; c <= 5; c++) begin
      s_ack_i = (c == 5); s_dat_i = 32'hA5A55A5A;
      #1;
      if (c == 5) begin
        check("lim_ack", m0_ack_o, 1);
        check("lim_dat", m0_dat_o, 32'hA5A55A5A);
        check("lim_noto", timeout_o, 0);
      end
      tick();
    end
    mstb[0] = 0; s_ack_i = 0;
    #1; check("lim_toadr", to_adr_o, 32'h2000);
    tick();
    tick();

    // Reset in the middle of a BUSY0 transfer with m1 pending.
    mstb[0] = 1; madr[0] = 32'h4000;
    tick();
    mstb[1] = 1; madr[1] = 32'h5000; rst_i = 0;
    tick();
    rst_i = 1; s_ack_i = 1; s_dat_i = 32'h29;
    #1; check("rstmid_stb", s_stb_o, 0); check("rstmid_ack0", m0_ack_o, 0); check("rstmid_ack1", m1_ack_o, 0);
    tick();
    #1; check("rstmid_win", s_adr_o, 32'h4000); check("rstmid_m1ack", m1_ack_o, 0);
    tick();
    mstb[0] = 0; s_ack_i = 0;
    tick();
    tick();

    // m1 withdraws its strobe while granted.
    mstb[1] = 0;
    #1; check("drop_ack", m1_ack_o, 0); check("drop_to", timeout_o, 0);
    tick();
    #1; check("drop_idle", s_stb_o, 0);
    mstb[0] = 1; madr[0] = 32'h6000; mstb[1] = 1; madr[1] = 32'h7000;
    tick();
    s_ack_i = 1;
    #1; check("drop_rr", s_adr_o, 32'h7000);
    tick();
    mstb[0] = 0; mstb[1] = 0; s_ack_i = 0;
    tick();
    tick();

    // Randomized traffic.
    sl_wait = 0;
    sl_target = $urandom_range(0, 6);
    for (int m = 0; m < 2; m++) exp_ack[m] = 0;
    for (int n = 0; n < 600; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (mstb[m] && exp_ack[m]) begin
          if ($urandom % 2 == 0) new_req(m); else mstb[m] = 0;
        end else if (mstb[m] && ($urandom % 24 == 0)) mstb[m] = 0;
        else if (!mstb[m] && ($urandom % 3 == 0)) new_req(m);
      end
      rst_i = ($urandom % 150 == 0) ? 1'b0 : 1'b1;
      bus_on = (owner >= 0) && mstb[owner];
      s_ack_i = bus_on && (sl_wait == sl_target);
      s_dat_i = $urandom;
      tick();
      if (bus_on && !s_ack_i && !exp_to) sl_wait++;
      else begin
        sl_wait = 0;
        sl_target = $urandom_range(0, 6);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the slave-cycle limit before the arbiter aborts a transfer (legal range 1..255).
REQ-002 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_i, input, 1: reset SHALL be synchronous and active-low, sampled on the rising edge of clk.
REQ-004 Ports m0_stb_i / m1_stb_i, input, 1 each: request strobes from master 0 (CPU) and master 1 (DMA).
REQ-005 Ports m0_we_i, m0_adr_i[31:0], m0_dat_i[31:0], m0_sel_i[3:0], and the same set for m1: per-master cycle attributes.
REQ-006 Ports m0_ack_o / m1_ack_o, output, 1 each: per-master acknowledge.
REQ-007 Ports m0_dat_o / m1_dat_o, output, 32 each: per-master read data.
REQ-008 Ports s_stb_o, s_we_o, s_adr_o[31:0], s_dat_o[31:0], s_sel_o[3:0], output: the shared slave bus.
REQ-009 Ports s_ack_i, input, 1, and s_dat_i, input, 32: slave acknowledge and read data.
REQ-010 Port timeout_o, output, 1: one-cycle pulse on an aborted transfer; port to_adr_o, output, 32: address of the last aborted transfer.

Function
REQ-011 The FSM SHALL have four states: IDLE, BUSY0, BUSY1 and RELEASE.
REQ-012 IDLE: with one request, SHALL go to BUSYx for that master on the next edge; with both requests, SHALL grant the master not granted most recently (round-robin bit last_gnt; after reset, m0 wins first).
REQ-013 In BUSYx, s_we/s_adr/s_dat/s_sel SHALL be combinational copies of master x's inputs, and s_stb_o SHALL equal mx_stb_i.
REQ-014 In IDLE and RELEASE, s_stb_o SHALL be 0 and the other slave outputs 0.
REQ-015 In BUSYx, mx_ack_o SHALL equal s_ack_i and mx_dat_o SHALL equal s_dat_i combinationally; the non-granted master SHALL see ack=0 and dat=0.
REQ-016 A sampled s_ack_i=1 in BUSYx SHALL update last_gnt=x and move to RELEASE; RELEASE SHALL always return to IDLE after exactly one cycle, masking the master's still-registered strobe.
REQ-017 Minimum turnaround: grant-to-grant SHALL be 3 cycles (BUSY with zero-wait ack, RELEASE, IDLE); arbitration latency from stb to s_stb_o SHALL be 1 cycle.
REQ-018 If mx_stb_i drops in BUSYx without ack, the FSM SHALL return to IDLE on the next edge with last_gnt unchanged.
REQ-019 An 8-bit wait counter SHALL clear on entry to BUSYx and increment each BUSYx cycle without s_ack_i.
REQ-020 When the counter equals TIMEOUT without ack, the arbiter SHALL, in that cycle, force mx_ack_o=1 and mx_dat_o=0, pulse timeout_o, and load to_adr_o with s_adr_o, then go to RELEASE; s_ack_i in the same cycle SHALL take precedence (normal completion, no timeout).
REQ-021 The counter SHALL NOT wrap; TIMEOUT bounds it.
REQ-022 Requests arriving in BUSY or RELEASE SHALL wait; they are never dropped while stb is held.

Reset
REQ-023 With rst_i=0 at an edge, the FSM SHALL enter IDLE, last_gnt=1 (so m0 wins the first tie), counter=0, timeout_o=0, to_adr_o=0.
REQ-024 Reset SHALL abort an in-flight transfer immediately: s_stb_o=0 and both ack outputs 0 from the first cycle after the reset edge.

Verification
REQ-025 m0 stb only, adr=0x100, slave acks after 2 waits with 0xCAFEF00D -> s_stb_o on cycle 1, m0_ack_o and m0_dat_o=0xCAFEF00D on cycle 3, RELEASE on cycle 4, IDLE on cycle 5.
REQ-026 m0 and m1 stb in the same cycle after reset, zero-wait slave -> grant order m0, m1, m0, m1 while both hold requests; m1_ack_o never set during a BUSY0 state.
REQ-027 TIMEOUT=4, m1 reads 0x2000 with no slave ack -> m1_ack_o=1 and m1_dat_o=0 in the 5th BUSY1 cycle, timeout_o one-cycle pulse, to_adr_o=0x2000.
REQ-028 TIMEOUT=4, slave acks exactly in the counter==4 cycle -> normal data returned, timeout_o stays 0.
REQ-029 rst_i driven low during BUSY0 with a pending m1 request -> next cycle IDLE, s_stb_o=0; after release, m0 wins any tie.
REQ-030 m1 drops stb in BUSY1 without ack -> IDLE next cycle, no ack, no timeout, last_gnt unchanged.
